regfile: RTL
============

REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DW, default 8: data width of every register and data port.
REQ-002 Parameter AW, default 2: register address width; the array holds 2**AW registers.
REQ-003 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 rs1_addr  input  AW  read port A address (instruction rs1 field).
REQ-007 rd_addr  input  AW  read port B address (instruction rd field).
REQ-008 rs1_data  output  DW  read port A data, drives ALU rs1_data.
REQ-009 rd_data  output  DW  read port B data, drives ALU rd_data.
REQ-010 wb_en  input  1  write-back request this cycle.
REQ-011 wb_addr  input  AW  write-back destination register.
REQ-012 wb_data  input  DW  write-back value (ALU out).
REQ-013 hazard  output  1  a read port would return stale data this cycle.

Function
REQ-014 Write path SHALL be two-stage: a rising edge with wb_en=1 captures wb_addr/wb_data into a pending register (pend_valid=1); the next rising edge commits pending data to array[pend_addr].
REQ-015 Each rising edge SHALL commit the current pending entry (if pend_valid) and load the new request; with wb_en=0 the edge clears pend_valid.
REQ-016 Back-to-back writes to the same address SHALL commit in order; the array holds the later value after both commit.
REQ-017 Read ports SHALL be combinational from the array (plus bypass when enabled, REQ-024); zero added latency.
REQ-018 Both read ports SHALL operate independently; rs1_addr == rd_addr returns identical data on both.
REQ-019 hazard SHALL be 1 iff bypass is disabled, pend_valid=1, and pend_addr equals rs1_addr or rd_addr; otherwise 0.
REQ-020 An incoming wb_en in the current cycle SHALL NOT affect read data or hazard until after the capturing edge.
REQ-021 All arithmetic is absent; data is stored and returned bit-exact across all DW bits, no sign handling.

Reset
REQ-022 rst=1 SHALL asynchronously clear every array register to 0 and pend_valid, pend_addr, pend_data to 0; a pending write is discarded, never committed.
REQ-023 During and after reset rs1_data=0, rd_data=0, hazard=0; wb_en is ignored while rst=1; first capture occurs on the first rising edge with rst=0.

Configuration
REQ-024 Macro REGFILE_BYPASS_EN defined: each read port whose address equals pend_addr while pend_valid=1 SHALL return pend_data instead of the array; hazard SHALL be constant 0.
REQ-025 Macro REGFILE_BYPASS_EN undefined: read ports SHALL return array contents only and hazard SHALL follow REQ-019.

Verification
REQ-026 Reset: write 8'h5A to reg 1, commit, assert rst -> all reads 8'h00, hazard=0; write captured then rst before commit -> reg read 8'h00.
REQ-027 Basic write: wb_en=1, wb_addr=2, wb_data=8'h33, then wb_en=0; after second edge rs1_addr=2 -> rs1_data=8'h33.
REQ-028 Bypass off: after capture edge of 8'hFE to reg 3, rd_addr=3 -> rd_data=old value 8'h00, hazard=1; after commit edge -> rd_data=8'hFE, hazard=0.
REQ-029 Bypass on: same stimulus -> rd_data=8'hFE immediately after capture edge, hazard=0 throughout.
REQ-030 Back-to-back: writes 8'h11 then 8'h22 to reg 0 on consecutive edges -> reg 0 reads 8'h22 after final commit; other regs unchanged.
REQ-031 Dual read: regs 0/1 hold 8'hA8/8'h89, rs1_addr=0, rd_addr=1 -> 8'hA8/8'h89; both addresses 1 -> 8'h89 on both.

Source files
------------

// File: rtl/regfile.sv
// Register file with a two-stage write-back path (capture, then commit) and two combinational read ports.
// Optional macro REGFILE_BYPASS_EN forwards pending data to the read ports and holds hazard at 0.
module regfile #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rs1_data,
    output logic [DW-1:0] rd_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          hazard
);

    localparam int unsigned NREG = 1 << AW;

    logic [DW-1:0] regs [NREG];
    logic          pend_valid;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;

    // Commit the pending entry, then capture this cycle's request into the pending slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs       <= '{default: '0};
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
        end else begin
            if (pend_valid) begin
                regs[pend_addr] <= pend_data;
            end
            pend_valid <= wb_en;
            if (wb_en) begin
                pend_addr <= wb_addr;
                pend_data <= wb_data;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // A read that hits the pending entry sees the value about to be committed
    always_comb begin
        rs1_data = regs[rs1_addr];
        rd_data  = regs[rd_addr];
        hazard   = 1'b0;
        if (pend_valid && (pend_addr == rs1_addr)) begin
            rs1_data = pend_data;
        end
        if (pend_valid && (pend_addr == rd_addr)) begin
            rd_data = pend_data;
        end
    end
`else
    // Array-only reads; flag any port that targets the uncommitted register
    always_comb begin
        rs1_data = regs[rs1_addr];
        rd_data  = regs[rd_addr];
        hazard   = pend_valid && ((pend_addr == rs1_addr) || (pend_addr == rd_addr));
    end
`endif

endmodule
